// File: rtl/axi_sram_slave.sv
// axi_sram_slave: AXI4 slave backed by a word register array.
// One burst in flight; IDLE arbitrates AW vs AR, then WDATA/WRESP or RDATA.
// Ports: ACLK, ARESETn (async, active low); AW*/W*/B* write channels;
// AR*/R* read channels. Only 32-bit data with 4-bit strobes is supported.
module axi_sram_slave #(
  parameter int ID_WIDTH    = 4,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int LEN_WIDTH   = 4,
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  input  logic [ID_WIDTH-1:0]     AWID,
  input  logic [ADDR_WIDTH-1:0]   AWAddr,
  input  logic [LEN_WIDTH-1:0]    AWLen,
  input  logic [2:0]              AWSize,
  input  logic [1:0]              AWBurst,
  input  logic                    AWValid,
  output logic                    AWReady,
  input  logic [DATA_WIDTH-1:0]   WData,
  input  logic [DATA_WIDTH/8-1:0] WStrb,
  input  logic                    WLast,
  input  logic                    WValid,
  output logic                    WReady,
  output logic [ID_WIDTH-1:0]     BID,
  output logic [1:0]              BResp,
  output logic                    BValid,
  input  logic                    BReady,
  input  logic [ID_WIDTH-1:0]     ARID,
  input  logic [ADDR_WIDTH-1:0]   ARAddr,
  input  logic [LEN_WIDTH-1:0]    ARLen,
  input  logic [2:0]              ARSize,
  input  logic [1:0]              ARBurst,
  input  logic                    ARValid,
  output logic                    ARReady,
  output logic [ID_WIDTH-1:0]     RID,
  output logic [DATA_WIDTH-1:0]   RData,
  output logic [1:0]              RResp,
  output logic                    RLast,
  output logic                    RValid,
  input  logic                    RReady
);

  localparam int IDX = $clog2(DEPTH_WORDS);
  localparam int SW  = DATA_WIDTH / 8;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WDATA = 2'd1;
  localparam logic [1:0] S_WRESP = 2'd2;
  localparam logic [1:0] S_RDATA = 2'd3;

  logic [1:0]            state;
  logic                  prio_w;
  logic [ID_WIDTH-1:0]   id_q;
  logic [IDX-1:0]        idx_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  cnt_q;
  logic                  fixed_q;
  logic                  err_q;
  logic                  mis_q;

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  logic                  idle;
  logic                  grant_w;
  logic                  aw_hs;
  logic                  ar_hs;
  logic                  w_hs;
  logic                  last_beat;
  logic [IDX-1:0]        idx_nxt;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [2:0]            a_size;
  logic [1:0]            a_burst;
  logic                  a_err;
  logic                  unused_addr;

  assign idle    = state == S_IDLE;
  assign grant_w = AWValid && (!ARValid || prio_w);
  assign AWReady = idle && grant_w;
  assign ARReady = idle && ARValid && !grant_w;
  assign WReady  = state == S_WDATA;
  assign BValid  = state == S_WRESP;
  assign RValid  = state == S_RDATA;

  assign aw_hs = AWValid && AWReady;
  assign ar_hs = ARValid && ARReady;
  assign w_hs  = WValid && WReady;

  // Address-phase fields of whichever channel wins arbitration.
  assign a_addr  = grant_w ? AWAddr  : ARAddr;
  assign a_size  = grant_w ? AWSize  : ARSize;
  assign a_burst = grant_w ? AWBurst : ARBurst;
  assign a_err   = (a_size != 3'b010) || a_burst[1]
                || (|a_addr[ADDR_WIDTH-1:IDX+2]);
  // Byte offset is dropped: accesses are word-aligned down.
  assign unused_addr = ^a_addr[1:0];

  assign last_beat = cnt_q == len_q;
  assign idx_nxt   = fixed_q ? idx_q : idx_q + IDX'(1);

  assign BID   = id_q;
  assign RID   = id_q;
  assign BResp = (err_q || mis_q) ? 2'b10 : 2'b00;
  assign RResp = err_q ? 2'b10 : 2'b00;
  assign RLast = RValid && last_beat;
  assign RData = (RValid && !err_q) ? mem[idx_q] : '0;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state   <= S_IDLE;
      prio_w  <= 1'b0;
      id_q    <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      fixed_q <= 1'b0;
      err_q   <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (aw_hs || ar_hs) begin
            id_q    <= grant_w ? AWID : ARID;
            len_q   <= grant_w ? AWLen : ARLen;
            idx_q   <= a_addr[IDX+1:2];
            fixed_q <= a_burst == 2'b00;
            cnt_q   <= '0;
            err_q   <= a_err;
            mis_q   <= 1'b0;
            prio_w  <= ar_hs;
            state   <= aw_hs ? S_WDATA : S_RDATA;
          end
        end
        S_WDATA: begin
          if (WValid) begin
            // The counter ends the burst; WLast only flags a mismatch.
            if (WLast != last_beat) mis_q <= 1'b1;
            if (last_beat) begin
              state <= S_WRESP;
            end else begin
              cnt_q <= cnt_q + LEN_WIDTH'(1);
              idx_q <= idx_nxt;
            end
          end
        end
        S_WRESP: begin
          if (BReady) state <= S_IDLE;
        end
        S_RDATA: begin
          if (RReady) begin
            if (last_beat) begin
              state <= S_IDLE;
            end else begin
              cnt_q <= cnt_q + LEN_WIDTH'(1);
              idx_q <= idx_nxt;
            end
          end
        end
      endcase
    end
  end

  // Storage is not reset; contents survive ARESETn.
  always_ff @(posedge ACLK) begin
    if (w_hs && !err_q) begin
      for (int b = 0; b < SW; b++) begin
        if (WStrb[b]) mem[idx_q][8*b +: 8] <= WData[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// tb_axi_sram_slave: directed + random bench for axi_sram_slave.
// Reference memory is a plain word array updated by AXI byte rules.
module tb_axi_sram_slave;

  localparam int IW    = 4;
  localparam int DEPTH = 64;
  localparam int IDX   = 6;

  logic          ACLK = 1'b0;
  logic          ARESETn = 1'b0;
  logic [IW-1:0] AWID, ARID, BID, RID;
  logic [31:0]   AWAddr, ARAddr, WData, RData;
  logic [3:0]    AWLen, ARLen, WStrb;
  logic [2:0]    AWSize, ARSize;
  logic [1:0]    AWBurst, ARBurst, BResp, RResp;
  logic          AWValid, AWReady, WLast, WValid, WReady;
  logic          BValid, BReady, ARValid, ARReady;
  logic          RLast, RValid, RReady;

  axi_sram_slave #(
    .ID_WIDTH(IW), .ADDR_WIDTH(32), .DATA_WIDTH(32),
    .LEN_WIDTH(4), .DEPTH_WORDS(DEPTH)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWID(AWID), .AWAddr(AWAddr), .AWLen(AWLen), .AWSize(AWSize),
    .AWBurst(AWBurst), .AWValid(AWValid), .AWReady(AWReady),
    .WData(WData), .WStrb(WStrb), .WLast(WLast), .WValid(WValid),
    .WReady(WReady),
    .BID(BID), .BResp(BResp), .BValid(BValid), .BReady(BReady),
    .ARID(ARID), .ARAddr(ARAddr), .ARLen(ARLen), .ARSize(ARSize),
    .ARBurst(ARBurst), .ARValid(ARValid), .ARReady(ARReady),
    .RID(RID), .RData(RData), .RResp(RResp), .RLast(RLast),
    .RValid(RValid), .RReady(RReady)
  );

  always #5 ACLK = ~ACLK;

  int checks = 0;
  int failures = 0;

  logic [31:0] model [DEPTH];
  logic [31:0] wd [16];
  logic [3:0]  ws [16];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_err(input logic [31:0] a, input logic [2:0] s,
                               input logic [1:0] b);
    return (s != 3'b010) || b[1] || ((a >> (IDX + 2)) != 0);
  endfunction

  task automatic aw_req(input logic [IW-1:0] id, input logic [31:0] a,
                        input logic [3:0] l, input logic [2:0] s,
                        input logic [1:0] b);
    int n = 0;
    AWID = id; AWAddr = a; AWLen = l; AWSize = s; AWBurst = b;
    AWValid = 1'b1;
    #1;
    while (!AWReady && n < 20) begin @(negedge ACLK); #1; n++; end
    chk("aw_accept", AWReady, 1'b1);
    @(posedge ACLK); @(negedge ACLK);
    AWValid = 1'b0;
  endtask

  task automatic ar_req(input logic [IW-1:0] id, input logic [31:0] a,
                        input logic [3:0] l, input logic [2:0] s,
                        input logic [1:0] b);
    int n = 0;
    ARID = id; ARAddr = a; ARLen = l; ARSize = s; ARBurst = b;
    ARValid = 1'b1;
    #1;
    while (!ARReady && n < 20) begin @(negedge ACLK); #1; n++; end
    chk("ar_accept", ARReady, 1'b1);
    @(posedge ACLK); @(negedge ACLK);
    ARValid = 1'b0;
  endtask

  task automatic w_beat(input logic [31:0] d, input logic [3:0] s,
                        input logic last);
    int n = 0;
    WData = d; WStrb = s; WLast = last; WValid = 1'b1;
    #1;
    while (!WReady && n < 20) begin @(negedge ACLK); #1; n++; end
    chk("w_ready", WReady, 1'b1);
    @(posedge ACLK); @(negedge ACLK);
    WValid = 1'b0; WLast = 1'b0;
  endtask

  task automatic b_take(input logic [IW-1:0] id, input logic [1:0] resp,
                        input int stall);
    #1;
    chk("b_valid", BValid, 1'b1);
    repeat (stall) begin
      @(negedge ACLK); #1;
      chk("b_hold", BValid, 1'b1);
    end
    BReady = 1'b1;
    #1;
    chk("b_id", BID, id);
    chk("b_resp", BResp, resp);
    @(posedge ACLK); @(negedge ACLK);
    BReady = 1'b0;
    #1;
    chk("b_done", BValid, 1'b0);
  endtask

  task automatic r_take(input logic [IW-1:0] id, input logic [31:0] d,
                        input logic last, input logic [1:0] resp,
                        input int stall);
    RReady = 1'b0;
    repeat (stall) begin
      #1;
      chk("r_valid_stall", RValid, 1'b1);
      chk("r_stable", RData, d);
      @(negedge ACLK);
    end
    RReady = 1'b1;
    #1;
    chk("r_valid", RValid, 1'b1);
    chk("r_data", RData, d);
    chk("r_last", RLast, last);
    chk("r_resp", RResp, resp);
    chk("r_id", RID, id);
    @(posedge ACLK); @(negedge ACLK);
    RReady = 1'b0;
  endtask

  task automatic do_write(input logic [IW-1:0] id, input logic [31:0] a,
                          input logic [3:0] l, input logic [2:0] s,
                          input logic [1:0] b, input int lastb,
                          input int stall);
    bit e = m_err(a, s, b);
    bit mis = (lastb != int'(l));
    int idx = int'((a >> 2) % DEPTH);
    aw_req(id, a, l, s, b);
    #1;
    chk("w_ready_lat", WReady, 1'b1);
    for (int k = 0; k <= int'(l); k++) begin
      w_beat(wd[k], ws[k], k == lastb);
      if (!e) begin
        for (int y = 0; y < 4; y++)
          if (ws[k][y]) model[idx][8*y +: 8] = wd[k][8*y +: 8];
      end
      if (b == 2'b01) idx = (idx + 1) % DEPTH;
    end
    b_take(id, (e || mis) ? 2'b10 : 2'b00, stall);
  endtask

  // mode 0: RReady always high; 1: one stall per beat; 2: random stalls
  task automatic do_read(input logic [IW-1:0] id, input logic [31:0] a,
                         input logic [3:0] l, input logic [2:0] s,
                         input logic [1:0] b, input int mode);
    bit e = m_err(a, s, b);
    int idx = int'((a >> 2) % DEPTH);
    int st;
    ar_req(id, a, l, s, b);
    for (int k = 0; k <= int'(l); k++) begin
      st = (mode == 0) ? 0 : (mode == 1) ? 1 : int'($urandom_range(0, 2));
      r_take(id, e ? 32'h0 : model[idx], k == int'(l),
             e ? 2'b10 : 2'b00, st);
      if (b == 2'b01) idx = (idx + 1) % DEPTH;
    end
    #1;
    chk("r_end", RValid, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra;
    logic [3:0]  rl;
    logic [1:0]  rb;

    AWID = '0; AWAddr = '0; AWLen = '0; AWSize = '0; AWBurst = '0;
    AWValid = 0; WData = '0; WStrb = '0; WLast = 0; WValid = 0;
    BReady = 0; ARID = '0; ARAddr = '0; ARLen = '0; ARSize = '0;
    ARBurst = '0; ARValid = 0; RReady = 0;

    repeat (3) @(negedge ACLK);
    #1;
    chk("rst_awready", AWReady, 1'b0);
    chk("rst_wready", WReady, 1'b0);
    chk("rst_bvalid", BValid, 1'b0);
    chk("rst_arready", ARReady, 1'b0);
    chk("rst_rvalid", RValid, 1'b0);
    chk("rst_rlast", RLast, 1'b0);
    chk("rst_ids", {BID, RID}, '0);
    chk("rst_resps", {BResp, RResp}, '0);
    chk("rst_rdata", RData, '0);
    ARESETn = 1'b1;
    @(negedge ACLK);

    // Preload the whole array with 16-beat INCR bursts.
    for (int blk = 0; blk < DEPTH / 16; blk++) begin
      for (int k = 0; k < 16; k++) begin
        wd[k] = $urandom; ws[k] = 4'hF;
      end
      do_write(IW'($urandom), 32'(blk * 64), 4'd15, 3'b010, 2'b01, 15, 0);
    end

    // Single write then read.
    wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
    do_write(4'h3, 32'h10, 4'd0, 3'b010, 2'b01, 0, 1);
    ar_req(4'h9, 32'h10, 4'd0, 3'b010, 2'b01);
    r_take(4'h9, 32'hDEADBEEF, 1'b1, 2'b00, 0);
    #1;
    chk("single_r_end", RValid, 1'b0);

    // INCR burst, read with RReady toggling.
    for (int k = 0; k < 4; k++) begin wd[k] = 32'(k + 1); ws[k] = 4'hF; end
    do_write(4'h5, 32'h20, 4'd3, 3'b010, 2'b01, 3, 0);
    do_read(4'h5, 32'h20, 4'd3, 3'b010, 2'b01, 1);

    // Strobes.
    wd[0] = 32'h11223344; ws[0] = 4'hF;
    do_write(4'h1, 32'h40, 4'd0, 3'b010, 2'b01, 0, 0);
    wd[0] = 32'hAABBCCDD; ws[0] = 4'h5;
    do_write(4'h1, 32'h40, 4'd0, 3'b010, 2'b01, 0, 2);
    ar_req(4'h2, 32'h40, 4'd0, 3'b010, 2'b01);
    r_take(4'h2, 32'h11BB33DD, 1'b1, 2'b00, 0);

    // Errors: bad size leaves memory alone; out-of-range read; WRAP read.
    wd[0] = 32'h0BADF00D; ws[0] = 4'hF;
    do_write(4'h2, 32'h40, 4'd0, 3'b001, 2'b01, 0, 0);
    do_read(4'h2, 32'h40, 4'd0, 3'b010, 2'b01, 0);
    do_read(4'h6, 32'(1 << (IDX + 2)), 4'd0, 3'b010, 2'b01, 0);
    do_read(4'h7, 32'h50, 4'd1, 3'b010, 2'b10, 2);

    // Early WLast on beat 1 of len 2, then missing WLast.
    for (int k = 0; k < 3; k++) begin wd[k] = $urandom; ws[k] = 4'hF; end
    do_write(4'h7, 32'h60, 4'd2, 3'b010, 2'b01, 1, 0);
    do_read(4'h7, 32'h60, 4'd2, 3'b010, 2'b01, 0);
    for (int k = 0; k < 3; k++) begin wd[k] = $urandom; ws[k] = 4'hF; end
    do_write(4'h8, 32'h60, 4'd2, 3'b010, 2'b01, 99, 1);
    do_read(4'h8, 32'h60, 4'd2, 3'b010, 2'b01, 0);

    // Index wrap and FIXED bursts.
    for (int k = 0; k < 4; k++) begin wd[k] = $urandom; ws[k] = 4'hF; end
    do_write(4'h1, 32'((DEPTH - 2) * 4), 4'd3, 3'b010, 2'b01, 3, 0);
    do_read(4'h1, 32'((DEPTH - 2) * 4), 4'd3, 3'b010, 2'b01, 0);
    do_read(4'h1, 32'h0, 4'd1, 3'b010, 2'b01, 0);
    for (int k = 0; k < 3; k++) begin wd[k] = $urandom; ws[k] = 4'hF; end
    do_write(4'h4, 32'h90, 4'd2, 3'b010, 2'b00, 2, 0);
    do_read(4'h4, 32'h90, 4'd2, 3'b010, 2'b00, 0);

    // Arbitration after a fresh reset; memory contents must survive.
    @(negedge ACLK);
    ARESETn = 1'b0;
    repeat (2) @(negedge ACLK);
    ARESETn = 1'b1;
    @(negedge ACLK);
    AWID = 4'hA; AWAddr = 32'h30; AWLen = 4'd0; AWSize = 3'b010;
    AWBurst = 2'b01; AWValid = 1'b1;
    ARID = 4'hB; ARAddr = 32'h30; ARLen = 4'd0; ARSize = 3'b010;
    ARBurst = 2'b01; ARValid = 1'b1;
    #1;
    chk("arb_rd_first", ARReady, 1'b1);
    chk("arb_aw_wait", AWReady, 1'b0);
    @(posedge ACLK); @(negedge ACLK);
    ARValid = 1'b0;
    #1;
    chk("arb_aw_blocked", AWReady, 1'b0);
    r_take(4'hB, model[12], 1'b1, 2'b00, 0);
    ARValid = 1'b1;
    #1;
    chk("arb_wr_next", AWReady, 1'b1);
    chk("arb_ar_wait", ARReady, 1'b0);
    @(posedge ACLK); @(negedge ACLK);
    AWValid = 1'b0;
    w_beat(32'h5A5A1234, 4'hF, 1'b1);
    model[12] = 32'h5A5A1234;
    b_take(4'hA, 2'b00, 0);
    AWValid = 1'b1;
    #1;
    chk("arb_rd_alt", ARReady, 1'b1);
    chk("arb_aw_alt", AWReady, 1'b0);
    @(posedge ACLK); @(negedge ACLK);
    ARValid = 1'b0; AWValid = 1'b0;
    r_take(4'hB, 32'h5A5A1234, 1'b1, 2'b00, 0);

    // Reset while beat 2 of a 4-beat read is presented.
    ar_req(4'h3, 32'h20, 4'd3, 3'b010, 2'b01);
    r_take(4'h3, model[8], 1'b0, 2'b00, 0);
    ARESETn = 1'b0;
    #1;
    chk("abort_rvalid", RValid, 1'b0);
    chk("abort_rdata", RData, 32'h0);
    @(posedge ACLK); #1;
    chk("abort_rvalid_edge", RValid, 1'b0);
    @(negedge ACLK);
    ARESETn = 1'b1;
    @(negedge ACLK);
    do_read(4'h3, 32'h20, 4'd3, 3'b010, 2'b01, 2);

    // Random write/read-back pairs.
    for (int t = 0; t < 25; t++) begin
      ra = 32'(($urandom_range(0, DEPTH - 1) << 2) | $urandom_range(0, 3));
      rl = 4'($urandom_range(0, 7));
      rb = 2'($urandom_range(0, 1));
      for (int k = 0; k < 16; k++) begin
        wd[k] = $urandom; ws[k] = 4'($urandom);
      end
      do_write(IW'($urandom), ra, rl, 3'b010, rb, int'(rl),
               int'($urandom_range(0, 2)));
      do_read(IW'($urandom), ra, rl, 3'b010, rb, 2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
